// File: rtl/eth_tx_arbiter_if.sv
// Signal bundle between three frame requesters, the transmit arbiter and the RGMII transmit path.
interface eth_tx_arbiter_if;
  logic [2:0]  i_req;
  logic [2:0]  o_grant;
  logic [7:0]  i_data0;
  logic [7:0]  i_data1;
  logic [7:0]  i_data2;
  logic [2:0]  i_valid;
  logic [2:0]  i_last;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        o_busy;
  logic        o_err;
  logic [15:0] o_frame_cnt;

  modport slave (
    input  i_req, i_data0, i_data1, i_data2, i_valid, i_last,
    output o_grant, o_tx_data, o_tx_valid, o_busy, o_err, o_frame_cnt
  );

  modport master (
    output i_req, i_data0, i_data1, i_data2, i_valid, i_last,
    input  o_grant, o_tx_data, o_tx_valid, o_busy, o_err, o_frame_cnt
  );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Round-robin arbiter that hands the RGMII transmit byte stream to one of three requesters per frame,
// enforcing a first-byte timeout, a maximum frame length and an inter-frame gap.
module eth_tx_arbiter #(
  parameter int IFG_BYTES = 12,
  parameter int WAIT_MAX  = 64,
  parameter int LEN_MAX   = 1536
) (
  input  logic             i_clk,
  input  logic             i_rst,
  eth_tx_arbiter_if.slave  bus
);
  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam int LW = $clog2(LEN_MAX + 1);
  localparam int IW = $clog2(IFG_BYTES + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);
  localparam logic [LW-1:0] LEN_LAST  = LW'(LEN_MAX);
  localparam logic [IW-1:0] IFG_LAST  = IW'(IFG_BYTES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, SEND = 2'd2, IFG = 2'd3} state_e;

  state_e        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [2:0]    grant_q, grant_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [LW-1:0] byte_cnt_q, byte_cnt_d;
  logic [IW-1:0] ifg_cnt_q, ifg_cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          busy_q;
  logic          err_q, err_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic [1:0]    win_s;
  logic [7:0]    g_data_s;
  logic          g_valid_s;
  logic          g_last_s;
  logic [LW-1:0] byte_inc_s;

  // Nearest requesting index after ptr, walking (ptr+1, ptr+2, ptr+3) mod 3.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      idx  = 2'((int'(ptr) + 1 + k) % 3);
      pick = req[idx] ? idx : pick;
    end
    return pick;
  endfunction

  assign win_s      = rr_pick(bus.i_req, ptr_q);
  assign byte_inc_s = byte_cnt_q + LW'(1);

  // Select the granted requester's byte lane.
  always_comb begin
    g_data_s  = 8'd0;
    g_valid_s = 1'b0;
    g_last_s  = 1'b0;
    case (grant_q)
      3'b001: begin g_data_s = bus.i_data0; g_valid_s = bus.i_valid[0]; g_last_s = bus.i_last[0]; end
      3'b010: begin g_data_s = bus.i_data1; g_valid_s = bus.i_valid[1]; g_last_s = bus.i_last[1]; end
      3'b100: begin g_data_s = bus.i_data2; g_valid_s = bus.i_valid[2]; g_last_s = bus.i_last[2]; end
      default: begin g_data_s = 8'd0; g_valid_s = 1'b0; g_last_s = 1'b0; end
    endcase
  end

  // Frame FSM next state, counters and output values.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    wait_cnt_d  = wait_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    ifg_cnt_d   = ifg_cnt_q;
    tx_data_d   = 8'd0;
    tx_valid_d  = 1'b0;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (|bus.i_req) begin
          ptr_d      = win_s;
          grant_d    = 3'b001 << win_s;
          wait_cnt_d = '0;
          byte_cnt_d = '0;
          state_d    = WAIT;
        end else begin
          grant_d    = 3'b000;
        end
      end
      WAIT, SEND: begin
        if (g_valid_s) begin
          tx_data_d  = g_data_s;
          tx_valid_d = 1'b1;
          byte_cnt_d = byte_inc_s;
          state_d    = SEND;
          // i_last wins over the length limit when both land on the same byte.
          if (g_last_s) begin
            grant_d     = 3'b000;
            frame_cnt_d = frame_cnt_q + 16'd1;
            ifg_cnt_d   = '0;
            state_d     = IFG;
          end else if (byte_inc_s == LEN_LAST) begin
            grant_d   = 3'b000;
            err_d     = 1'b1;
            ifg_cnt_d = '0;
            state_d   = IFG;
          end else begin
            state_d   = SEND;
          end
        end else if (state_q == WAIT) begin
          if (wait_cnt_q == WAIT_LAST) begin
            grant_d = 3'b000;
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            wait_cnt_d = wait_cnt_q + WW'(1);
          end
        end else begin
          grant_d   = 3'b000;
          err_d     = 1'b1;
          ifg_cnt_d = '0;
          state_d   = IFG;
        end
      end
      IFG: begin
        // The gap is counted only once the last forwarded byte has left the output register.
        if (!tx_valid_q) begin
          if (ifg_cnt_q == IFG_LAST) begin
            ifg_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            ifg_cnt_d = ifg_cnt_q + IW'(1);
          end
        end else begin
          ifg_cnt_d = ifg_cnt_q;
        end
      end
      default: begin
        grant_d = 3'b000;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd2;
      grant_q     <= 3'b000;
      wait_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      ifg_cnt_q   <= '0;
      tx_data_q   <= 8'd0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      wait_cnt_q  <= wait_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      ifg_cnt_q   <= ifg_cnt_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= (state_d != IDLE);
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.o_grant     = grant_q;
  assign bus.o_tx_data   = tx_data_q;
  assign bus.o_tx_valid  = tx_valid_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_err       = err_q;
  assign bus.o_frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: dut_a uses default parameters, dut_b limits frames to 16 bytes;
// both see the same requester stimulus.
module tb_eth_tx_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic [2:0] valid;
  logic [2:0] last;
  logic [7:0] d0, d1, d2;
  int checks = 0;
  int passes = 0;

  eth_tx_arbiter_if bus_a ();
  eth_tx_arbiter_if bus_b ();

  assign bus_a.i_req = req;   assign bus_b.i_req = req;
  assign bus_a.i_valid = valid; assign bus_b.i_valid = valid;
  assign bus_a.i_last = last; assign bus_b.i_last = last;
  assign bus_a.i_data0 = d0;  assign bus_b.i_data0 = d0;
  assign bus_a.i_data1 = d1;  assign bus_b.i_data1 = d1;
  assign bus_a.i_data2 = d2;  assign bus_b.i_data2 = d2;

  eth_tx_arbiter dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a));
  eth_tx_arbiter #(.IFG_BYTES(12), .WAIT_MAX(64), .LEN_MAX(16)) dut_b (.i_clk(clk), .i_rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int g, input logic [7:0] d, input logic v, input logic l);
    valid[g] = v;
    last[g]  = l;
    case (g)
      0:       d0 = d;
      1:       d1 = d;
      default: d2 = d;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b0; req = 3'b000; valid = 3'b000; last = 3'b000;
    d0 = 8'd0; d1 = 8'd0; d2 = 8'd0;
    tick(); tick();
    rst = 1'b1;
  endtask

  // Ticks until dut_a grants, checking the winner, the tick count and that tx stayed quiet.
  task automatic wait_grant(input string tag, input logic [2:0] exp_g, input int exp_ticks);
    int   n = 0;
    logic quiet = 1'b1;
    while (bus_a.o_grant == 3'b000 && n < 200) begin
      tick();
      n++;
      quiet = quiet & ~bus_a.o_tx_valid;
    end
    chk({tag, "_grant"}, 32'(bus_a.o_grant), 32'(exp_g));
    chk({tag, "_ticks"}, 32'(n), 32'(exp_ticks));
    chk({tag, "_quiet"}, 32'(quiet), 32'd1);
  endtask

  initial begin
    int g;
    int nm;
    int nb;
    int ne;

    // Reset values
    do_reset();
    chk("rst_grant", 32'(bus_a.o_grant), 32'd0);
    chk("rst_txv",   32'(bus_a.o_tx_valid), 32'd0);
    chk("rst_txd",   32'(bus_a.o_tx_data), 32'd0);
    chk("rst_busy",  32'(bus_a.o_busy), 32'd0);
    chk("rst_err",   32'(bus_a.o_err), 32'd0);
    chk("rst_cnt",   32'(bus_a.o_frame_cnt), 32'd0);

    // Round robin with all three requesting, one-byte frames
    req = 3'b111;
    for (int f = 0; f < 4; f++) begin
      g = f % 3;
      wait_grant("rr", 3'b001 << g, (f == 0) ? 1 : 14);
      put(g, 8'hA0 + 8'(f), 1'b1, 1'b1);
      tick();
      chk("rr_txd",   32'(bus_a.o_tx_data), 32'h0A0 + 32'(f));
      chk("rr_txv",   32'(bus_a.o_tx_valid), 32'd1);
      chk("rr_gnt0",  32'(bus_a.o_grant), 32'd0);
      chk("rr_cnt",   32'(bus_a.o_frame_cnt), 32'(f + 1));
      chk("rr_err",   32'(bus_a.o_err), 32'd0);
      put(g, 8'd0, 1'b0, 1'b0);
    end

    // 64-byte frame from requester 1 with noise on the other lanes
    do_reset();
    req = 3'b010;
    valid = 3'b101; d0 = 8'hEE; d2 = 8'hEE;
    wait_grant("f64", 3'b010, 1);
    req = 3'b000;
    nm = 0;
    for (int i = 0; i < 64; i++) begin
      put(1, 8'(i), 1'b1, (i == 63));
      tick();
      nm += (bus_a.o_tx_valid === 1'b1 && bus_a.o_tx_data === 8'(i)) ? 1 : 0;
    end
    chk("f64_bytes", 32'(nm), 32'd64);
    chk("f64_gnt0",  32'(bus_a.o_grant), 32'd0);
    chk("f64_cnt",   32'(bus_a.o_frame_cnt), 32'd1);
    chk("f64_err",   32'(bus_a.o_err), 32'd0);
    put(1, 8'd0, 1'b0, 1'b0);
    req = 3'b001;
    wait_grant("f64_gap", 3'b001, 14);

    // First-byte timeout
    do_reset();
    req = 3'b101;
    wait_grant("to", 3'b001, 1);
    req = 3'b100;
    nb = 0;
    while (bus_a.o_err !== 1'b1 && nb < 100) begin
      tick();
      nb++;
    end
    chk("to_cycles", 32'(nb), 32'd64);
    chk("to_gnt0",   32'(bus_a.o_grant), 32'd0);
    chk("to_txv",    32'(bus_a.o_tx_valid), 32'd0);
    tick();
    chk("to_pulse",  32'(bus_a.o_err), 32'd0);
    chk("to_next",   32'(bus_a.o_grant), 32'b100);
    chk("to_cnt",    32'(bus_a.o_frame_cnt), 32'd0);

    // Abort: valid drops after 10 of 20 bytes
    do_reset();
    req = 3'b001;
    wait_grant("ab", 3'b001, 1);
    req = 3'b000;
    nm = 0;
    for (int i = 1; i <= 10; i++) begin
      put(0, 8'(i), 1'b1, 1'b0);
      tick();
      nm += (bus_a.o_tx_valid === 1'b1 && bus_a.o_tx_data === 8'(i)) ? 1 : 0;
    end
    chk("ab_bytes", 32'(nm), 32'd10);
    put(0, 8'd0, 1'b0, 1'b0);
    tick();
    chk("ab_txv",  32'(bus_a.o_tx_valid), 32'd0);
    chk("ab_txd",  32'(bus_a.o_tx_data), 32'd0);
    chk("ab_err",  32'(bus_a.o_err), 32'd1);
    chk("ab_gnt0", 32'(bus_a.o_grant), 32'd0);
    chk("ab_cnt",  32'(bus_a.o_frame_cnt), 32'd0);
    req = 3'b010;
    wait_grant("ab_gap", 3'b010, 13);

    // LEN_MAX=16: 20-byte frame is truncated
    do_reset();
    req = 3'b001;
    wait_grant("tr", 3'b001, 1);
    chk("tr_gnt_b", 32'(bus_b.o_grant), 32'b001);
    req = 3'b000;
    nb = 0; nm = 0; ne = 0;
    for (int i = 1; i <= 20; i++) begin
      put(0, 8'(i), 1'b1, (i == 20));
      tick();
      nb += (bus_b.o_tx_valid === 1'b1) ? 1 : 0;
      nm += (bus_b.o_tx_valid === 1'b1 && bus_b.o_tx_data === 8'(i)) ? 1 : 0;
      ne += (bus_b.o_err === 1'b1) ? 1 : 0;
      if (i == 16) begin
        chk("tr_err16",  32'(bus_b.o_err), 32'd1);
        chk("tr_gnt16",  32'(bus_b.o_grant), 32'd0);
      end
    end
    chk("tr_nbytes", 32'(nb), 32'd16);
    chk("tr_match",  32'(nm), 32'd16);
    chk("tr_nerr",   32'(ne), 32'd1);
    chk("tr_cnt",    32'(bus_b.o_frame_cnt), 32'd0);

    // LEN_MAX=16: i_last on byte 16 is a normal end
    do_reset();
    req = 3'b001;
    wait_grant("eq", 3'b001, 1);
    req = 3'b000;
    nb = 0; ne = 0;
    for (int i = 1; i <= 16; i++) begin
      put(0, 8'(i), 1'b1, (i == 16));
      tick();
      nb += (bus_b.o_tx_valid === 1'b1) ? 1 : 0;
      ne += (bus_b.o_err === 1'b1) ? 1 : 0;
    end
    put(0, 8'd0, 1'b0, 1'b0);
    tick();
    ne += (bus_b.o_err === 1'b1) ? 1 : 0;
    chk("eq_nbytes", 32'(nb), 32'd16);
    chk("eq_nerr",   32'(ne), 32'd0);
    chk("eq_cnt",    32'(bus_b.o_frame_cnt), 32'd1);
    chk("eq_gnt0",   32'(bus_b.o_grant), 32'd0);

    // Reset during byte 5 of a frame
    do_reset();
    req = 3'b001;
    wait_grant("mr", 3'b001, 1);
    put(0, 8'h55, 1'b1, 1'b1);
    tick();
    chk("mr_cnt1", 32'(bus_a.o_frame_cnt), 32'd1);
    put(0, 8'd0, 1'b0, 1'b0);
    wait_grant("mr_next", 3'b001, 14);
    for (int i = 1; i <= 4; i++) begin
      put(0, 8'(i), 1'b1, 1'b0);
      tick();
    end
    chk("mr_mid_txv", 32'(bus_a.o_tx_valid), 32'd1);
    put(0, 8'd5, 1'b1, 1'b0);
    rst = 1'b0;
    tick();
    chk("mr_grant", 32'(bus_a.o_grant), 32'd0);
    chk("mr_txv",   32'(bus_a.o_tx_valid), 32'd0);
    chk("mr_txd",   32'(bus_a.o_tx_data), 32'd0);
    chk("mr_busy",  32'(bus_a.o_busy), 32'd0);
    chk("mr_err",   32'(bus_a.o_err), 32'd0);
    chk("mr_cnt",   32'(bus_a.o_frame_cnt), 32'd0);
    rst = 1'b1;
    req = 3'b000;
    put(0, 8'd0, 1'b0, 1'b0);
    tick();
    chk("mr_post_err",  32'(bus_a.o_err), 32'd0);
    chk("mr_post_busy", 32'(bus_a.o_busy), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
